// File: rtl/c16_pkg.sv
// rtl/c16_pkg.sv - shared c16 types: loader state encoding and default frame marker
package c16_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CK_HI,
        ST_CK_LO,
        ST_DONE
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - host byte stream in, instruction-RAM write port and status out
interface imem_loader_if #(
    parameter int ADDR_W = 16
) ();

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic              mem_wren;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    // master: host side feeding bytes and watching the RAM port / status
    modport master (
        output in_data, in_valid,
        input  in_ready, mem_addr, mem_data, mem_wren, cpu_hold, load_done, load_err
    );

    // slave: the loader itself
    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_addr, mem_data, mem_wren, cpu_hold, load_done, load_err
    );

endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader into instruction RAM; IMEM_LOADER_CHECKSUM_EN adds a 16-bit frame checksum
module imem_loader
    import c16_pkg::*;
#(
    parameter int         ADDR_W    = 16,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t ST_AFTER_DATA = ST_CK_HI;
`else
    localparam loader_state_t ST_AFTER_DATA = ST_DONE;
`endif

    loader_state_t     state_q, state_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_data_q, mem_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic              in_ready_q, in_ready_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_done_q, load_done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [15:0]       sum_q, sum_d;
    logic              load_err_q, load_err_d;
`endif

    logic        in_xfer;
    logic [15:0] word;

    assign in_xfer = bus.in_valid && in_ready_q;
    // hi_q is the only assembly register; every 16-bit field pairs it with the current byte
    assign word    = {hi_q, bus.in_data};

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wren_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        load_err_d = load_err_q;
`endif
        if (in_xfer) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_data == SYNC_BYTE) begin
                        state_d = ST_ADDR_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d      = 16'd0;
                        load_err_d = 1'b0;
`endif
                    end
                end
                ST_ADDR_HI: begin
                    hi_d    = bus.in_data;
                    state_d = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    ptr_d   = ADDR_W'(word);
                    state_d = ST_CNT_HI;
                end
                ST_CNT_HI: begin
                    hi_d    = bus.in_data;
                    state_d = ST_CNT_LO;
                end
                ST_CNT_LO: begin
                    cnt_d   = word;
                    state_d = (word == 16'd0) ? ST_AFTER_DATA : ST_DATA_HI;
                end
                ST_DATA_HI: begin
                    hi_d    = bus.in_data;
                    state_d = ST_DATA_LO;
                end
                ST_DATA_LO: begin
                    mem_addr_d = ptr_q;
                    mem_data_d = word;
                    mem_wren_d = 1'b1;
                    ptr_d      = ptr_q + ADDR_W'(1);
                    cnt_d      = cnt_q - 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + word;
`endif
                    state_d    = (cnt_q == 16'd1) ? ST_AFTER_DATA : ST_DATA_HI;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CK_HI: begin
                    hi_d    = bus.in_data;
                    state_d = ST_CK_LO;
                end
                ST_CK_LO: begin
                    load_err_d = (word != sum_q);
                    state_d    = ST_DONE;
                end
`endif
                default: ;
            endcase
        end
        // DONE never accepts a byte, so it always falls straight back to IDLE
        if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
        in_ready_d  = (state_d != ST_DONE);
        cpu_hold_d  = (state_d != ST_IDLE);
        load_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hi_q        <= 8'd0;
            ptr_q       <= '0;
            cnt_q       <= 16'd0;
            mem_addr_q  <= '0;
            mem_data_q  <= 16'd0;
            mem_wren_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= 16'd0;
            load_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_wren_q  <= mem_wren_d;
            in_ready_q  <= in_ready_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
            load_err_q  <= load_err_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.mem_wren  = mem_wren_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.load_done = load_done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.load_err  = load_err_q;
`else
    assign bus.load_err  = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader; honours IMEM_LOADER_CHECKSUM_EN
module tb_imem_loader;

    localparam int         ADDR_W = 16;
    localparam logic [7:0] SYNC   = 8'hA5;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CKB = 2;
`else
    localparam int CKB = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Frame-position model: byte k after SYNC has a fixed meaning in the frame
    logic        m_ready, m_hold, m_wren, m_done, m_err, m_in_frame;
    logic [15:0] m_addr, m_data, m_base, m_cnt, m_sum;
    logic [7:0]  m_prev;
    int          m_k;

    always @(posedge clk) begin : model
        int          k;
        int          last;
        logic [15:0] cnt;
        logic [15:0] w;
        if (reset) begin
            m_ready <= 0; m_hold <= 0; m_wren <= 0; m_done <= 0; m_err <= 0;
            m_in_frame <= 0; m_addr <= 0; m_data <= 0; m_base <= 0; m_cnt <= 0;
            m_sum <= 0; m_prev <= 0; m_k <= 0;
        end else begin
            m_wren <= 0;
            m_done <= 0;
            if (m_done) begin
                m_ready <= 1; m_hold <= 0; m_in_frame <= 0;
            end else begin
                m_ready <= 1;
                if (bus.in_valid && m_ready) begin
                    if (!m_in_frame) begin
                        if (bus.in_data == SYNC) begin
                            m_in_frame <= 1; m_k <= 0; m_hold <= 1; m_err <= 0; m_sum <= 0;
                        end
                    end else begin
                        k = m_k + 1;
                        m_k <= k;
                        m_prev <= bus.in_data;
                        w = {m_prev, bus.in_data};
                        cnt = m_cnt;
                        if (k == 2) m_base <= w;
                        if (k == 4) begin cnt = w; m_cnt <= w; end
                        if (k >= 6 && k <= 4 + 2 * int'(cnt) && (k % 2 == 0)) begin
                            m_wren <= 1;
                            m_addr <= m_base + 16'((k - 6) / 2);
                            m_data <= w;
                            m_sum  <= m_sum + w;
                        end
                        last = 4 + 2 * int'(cnt) + CKB;
                        if (k == last) begin
                            m_done  <= 1;
                            m_ready <= 0;
                            if (CKB != 0) m_err <= (w != m_sum);
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",  {31'd0, bus.in_ready},  {31'd0, m_ready});
            check("cpu_hold",  {31'd0, bus.cpu_hold},  {31'd0, m_hold});
            check("mem_wren",  {31'd0, bus.mem_wren},  {31'd0, m_wren});
            check("load_done", {31'd0, bus.load_done}, {31'd0, m_done});
            check("load_err",  {31'd0, bus.load_err},  {31'd0, m_err});
            check("mem_addr",  {16'd0, bus.mem_addr},  {16'd0, m_addr});
            check("mem_data",  {16'd0, bus.mem_data},  {16'd0, m_data});
        end
    end

    // Activity log used by the literal per-test expectations
    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int hold_cycles = 0;
    int done_pulses = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (bus.mem_wren) begin
                wr_addr.push_back(bus.mem_addr);
                wr_data.push_back(bus.mem_data);
            end
            if (bus.cpu_hold)  hold_cycles++;
            if (bus.load_done) done_pulses++;
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        hold_cycles = 0;
        done_pulses = 0;
    endtask

    task automatic expect_write(input int idx, input logic [15:0] a, input logic [15:0] d);
        if (idx < wr_addr.size()) begin
            check($sformatf("wr%0d_addr", idx), {16'd0, wr_addr[idx]}, {16'd0, a});
            check($sformatf("wr%0d_data", idx), {16'd0, wr_data[idx]}, {16'd0, d});
        end else begin
            check($sformatf("wr%0d_present", idx), 32'd0, 32'd1);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        repeat (gap) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tries = 0;
        while (!bus.in_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 50) check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] addr, input int n,
                              input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] ck_adj,
                              input int gap);
        logic [15:0] ws[3];
        logic [15:0] sum;
        ws[0] = w0; ws[1] = w1; ws[2] = w2;
        sum = 16'd0;
        send_byte(SYNC, gap);
        send_byte(addr[15:8], gap);
        send_byte(addr[7:0], gap);
        send_byte(8'(n >> 8), gap);
        send_byte(8'(n), gap);
        for (int i = 0; i < n; i++) begin
            send_byte(ws[i][15:8], gap);
            send_byte(ws[i][7:0], gap);
            sum = sum + ws[i];
        end
        if (CKB != 0) begin
            sum = sum + ck_adj;
            send_byte(sum[15:8], gap);
            send_byte(sum[7:0], gap);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
        check("rst_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        clear_log();

        // Two words, in_valid held high
        send_frame(16'h0010, 2, 16'h1234, 16'hABCD, 16'h0000, 16'd0, 0);
        idle(4);
        check("A_writes", wr_addr.size(), 2);
        expect_write(0, 16'h0010, 16'h1234);
        expect_write(1, 16'h0011, 16'hABCD);
        check("A_done", done_pulses, 1);
        check("A_hold", hold_cycles, 9 + CKB);
        clear_log();

        // Junk before SYNC, then a zero-count frame
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        idle(2);
        check("B_junk_hold", hold_cycles, 0);
        send_frame(16'h0000, 0, 16'h0, 16'h0, 16'h0, 16'd0, 0);
        idle(4);
        check("B_writes", wr_addr.size(), 0);
        check("B_done", done_pulses, 1);
        check("B_hold", hold_cycles, 5 + CKB);
        clear_log();

        // Address wrap
        send_frame(16'hFFFF, 2, 16'h1111, 16'h2222, 16'h0000, 16'd0, 0);
        idle(4);
        check("W_writes", wr_addr.size(), 2);
        expect_write(0, 16'hFFFF, 16'h1111);
        expect_write(1, 16'h0000, 16'h2222);
        clear_log();

        // in_valid toggling, SYNC value embedded as data
        send_frame(16'h0100, 3, 16'hDEAD, 16'hA5A5, 16'h0A5A, 16'd0, 1);
        idle(4);
        check("T_writes", wr_addr.size(), 3);
        expect_write(0, 16'h0100, 16'hDEAD);
        expect_write(1, 16'h0101, 16'hA5A5);
        expect_write(2, 16'h0102, 16'h0A5A);
        check("T_done", done_pulses, 1);
        clear_log();

        // Reset after DATA_HI of word 2
        send_byte(SYNC, 0);
        send_byte(8'h00, 0); send_byte(8'h20, 0);
        send_byte(8'h00, 0); send_byte(8'h03, 0);
        send_byte(8'h11, 0); send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("R_hold", {31'd0, bus.cpu_hold}, 32'd0);
        check("R_ready", {31'd0, bus.in_ready}, 32'd0);
        reset = 1'b0;
        idle(3);
        check("R_writes", wr_addr.size(), 1);
        expect_write(0, 16'h0020, 16'h1111);
        check("R_done", done_pulses, 0);
        clear_log();
        send_frame(16'h0030, 1, 16'h5566, 16'h0, 16'h0, 16'd0, 0);
        idle(4);
        check("R2_writes", wr_addr.size(), 1);
        expect_write(0, 16'h0030, 16'h5566);
        check("R2_done", done_pulses, 1);
        clear_log();

`ifdef IMEM_LOADER_CHECKSUM_EN
        send_frame(16'h0040, 2, 16'h0001, 16'h0002, 16'h0, 16'd0, 0);
        idle(3);
        check("CK_good_err", {31'd0, bus.load_err}, 32'd0);
        send_frame(16'h0040, 2, 16'h0001, 16'h0002, 16'h0, 16'd1, 0);
        idle(6);
        check("CK_bad_err", {31'd0, bus.load_err}, 32'd1);
        check("CK_bad_done", done_pulses, 2);
        send_byte(SYNC, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("CK_sync_clr", {31'd0, bus.load_err}, 32'd0);
        send_byte(8'h00, 0); send_byte(8'h50, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        idle(4);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
